// File: rtl/adrv9001_axis_pattern_gen.sv
// AXI4-Stream IQ test-pattern source for the ADRV9001 TX path.
// Enable-gated sessions with start/stop delays, tlast framing and ramp/const/PRBS15/toggle patterns.
module adrv9001_axis_pattern_gen #(
    parameter int unsigned PKT_WIDTH = 10,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 enable,
    input  logic [1:0]           mode,
    input  logic [31:0]          const_data,
    input  logic [PKT_WIDTH-1:0] pkt_len,
    input  logic [CNT_WIDTH-1:0] enable_cnt,
    input  logic [CNT_WIDTH-1:0] disable_cnt,
    output logic [31:0]          m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tlast,
    output logic                 active,
    output logic [CNT_WIDTH-1:0] pkt_count
);

    typedef enum logic [2:0] {
        IDLE,
        EN_DELAY,
        STREAM,
        DIS_DELAY,
        FLUSH
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [CNT_WIDTH-1:0] dly_cnt;
    logic [1:0]           mode_q;
    logic [31:0]          const_q;
    logic [PKT_WIDTH-1:0] len_q;
    logic [PKT_WIDTH-1:0] beat;
    logic [15:0]          ramp;
    logic [14:0]          lfsr;
    logic                 parity;
    logic [31:0]          word;
    logic                 start;
    logic                 xfer;
    logic                 at_last;

    assign start   = (state == IDLE) && enable;
    assign xfer    = m_axis_tvalid && m_axis_tready;
    assign at_last = (beat == len_q);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (enable) state_next = EN_DELAY;
            end
            EN_DELAY: begin
                if (!enable)           state_next = IDLE;
                else if (dly_cnt == '0) state_next = STREAM;
            end
            STREAM: begin
                if (!enable) state_next = DIS_DELAY;
            end
            DIS_DELAY: begin
                if (enable)             state_next = STREAM;
                else if (dly_cnt == '0) state_next = FLUSH;
            end
            FLUSH: begin
                // Only a completed tlast handshake may close the session.
                if (xfer && at_last) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dly_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) dly_cnt <= enable_cnt;
                end
                EN_DELAY: begin
                    if (enable && dly_cnt != '0) dly_cnt <= dly_cnt - CNT_WIDTH'(1);
                end
                STREAM: begin
                    if (!enable) dly_cnt <= disable_cnt;
                end
                DIS_DELAY: begin
                    if (!enable && dly_cnt != '0) dly_cnt <= dly_cnt - CNT_WIDTH'(1);
                end
                default: dly_cnt <= dly_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mode_q    <= '0;
            const_q   <= '0;
            len_q     <= '0;
            beat      <= '0;
            ramp      <= '0;
            lfsr      <= '1;
            parity    <= 1'b0;
            pkt_count <= '0;
        end else if (start) begin
            mode_q    <= mode;
            const_q   <= const_data;
            len_q     <= pkt_len;
            beat      <= '0;
            ramp      <= '0;
            lfsr      <= '1;
            parity    <= 1'b0;
            pkt_count <= '0;
        end else if (xfer) begin
            beat   <= at_last ? '0 : beat + PKT_WIDTH'(1);
            ramp   <= ramp + 16'd1;
            // x^15 + x^14 + 1, Fibonacci form shifting toward the MSB.
            lfsr   <= {lfsr[13:0], lfsr[14] ^ lfsr[13]};
            parity <= ~parity;
            if (at_last && pkt_count != '1) pkt_count <= pkt_count + CNT_WIDTH'(1);
        end
    end

    always_comb begin
        word = '0;
        case (mode_q)
            2'd0:    word = {ramp, ~ramp};
            2'd1:    word = const_q;
            2'd2:    word = {1'b0, lfsr, 1'b0, ~lfsr};
            default: word = parity ? ~const_q : const_q;
        endcase
    end

    always_comb begin
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tdata  = '0;
        active        = (state != IDLE);
        if (state == STREAM || state == DIS_DELAY || state == FLUSH) begin
            m_axis_tvalid = 1'b1;
            m_axis_tlast  = at_last;
            m_axis_tdata  = word;
        end
    end

endmodule

// File: tb/tb_adrv9001_axis_pattern_gen.sv
// Randomised self-checking bench for adrv9001_axis_pattern_gen against a beat-index reference model.
module tb_adrv9001_axis_pattern_gen;

    logic        clk  = 1'b0;
    logic        rstn = 1'b1;
    logic        en   = 1'b0;
    logic        rdy  = 1'b1;
    logic [1:0]  md   = 2'd0;
    logic [31:0] cd   = 32'd0;
    logic [9:0]  pl   = 10'd0;
    logic [15:0] ec   = 16'd0;
    logic [15:0] dc   = 16'd0;

    logic [31:0] tdata;
    logic        tvalid;
    logic        tlast;
    logic        act;
    logic [15:0] pcnt;

    int total = 0;
    int bad   = 0;
    logic armed = 1'b0;

    adrv9001_axis_pattern_gen #(.PKT_WIDTH(10), .CNT_WIDTH(16)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .enable        (en),
        .mode          (md),
        .const_data    (cd),
        .pkt_len       (pl),
        .enable_cnt    (ec),
        .disable_cnt   (dc),
        .m_axis_tdata  (tdata),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (rdy),
        .m_axis_tlast  (tlast),
        .active        (act),
        .pkt_count     (pcnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: the session is described by its beat index n; every output follows from n.
    logic [14:0] prbs [32767];
    bit          m_on    = 0;
    bit          m_valid = 0;
    bit          m_stop  = 0;
    bit          m_flush = 0;
    int          m_cnt   = 0;
    int          m_n     = 0;
    int          m_pkts  = 0;
    int          m_len   = 0;
    logic [1:0]  m_mode  = 2'd0;
    logic [31:0] m_const = 32'd0;

    function automatic logic [14:0] prbs_step(input logic [14:0] s);
        return {s[13:0], s[14] ^ s[13]};
    endfunction

    function automatic logic [31:0] exp_word(input int n, input logic [1:0] mo, input logic [31:0] c);
        logic [15:0] r;
        logic [14:0] l;
        r = 16'(n);
        l = prbs[n % 32767];
        case (mo)
            2'd0:    return {r, ~r};
            2'd1:    return c;
            2'd2:    return {1'b0, l, 1'b0, ~l};
            default: return n[0] ? ~c : c;
        endcase
    endfunction

    function automatic bit exp_last(input int n, input int len);
        return (n % (len + 1)) == len;
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_on = 0; m_valid = 0; m_stop = 0; m_flush = 0;
            m_cnt = 0; m_n = 0; m_pkts = 0;
        end else if (!m_on) begin
            if (en) begin
                m_on = 1; m_valid = 0; m_stop = 0; m_flush = 0;
                m_cnt = int'(ec); m_n = 0; m_pkts = 0;
                m_mode = md; m_const = cd; m_len = int'(pl);
            end
        end else if (!m_valid) begin
            if (!en)             m_on = 0;
            else if (m_cnt == 0) m_valid = 1;
            else                 m_cnt--;
        end else begin
            bit last;
            last = exp_last(m_n, m_len);
            if (m_flush) begin
                if (rdy && last) begin m_on = 0; m_valid = 0; end
            end else if (!m_stop) begin
                if (!en) begin m_stop = 1; m_cnt = int'(dc); end
            end else if (en)     m_stop = 0;
            else if (m_cnt == 0) m_flush = 1;
            else                 m_cnt--;
            if (rdy) begin
                m_n++;
                if (last && m_pkts < 65535) m_pkts++;
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check("tvalid", {31'd0, tvalid}, {31'd0, m_valid});
            check("active", {31'd0, act}, {31'd0, m_on});
            check("pkt_count", {16'd0, pcnt}, m_pkts);
            if (m_valid) begin
                check("tdata", tdata, exp_word(m_n, m_mode, m_const));
                check("tlast", {31'd0, tlast}, {31'd0, exp_last(m_n, m_len)});
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_valid(input int budget);
        int k = 0;
        while (!tvalid && k < budget) begin tick(); k++; end
        check("wait_valid", {31'd0, tvalid}, 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (act && k < budget) begin tick(); k++; end
        check("wait_idle", {31'd0, act}, 32'd0);
    endtask

    initial begin
        logic [31:0] save;
        logic [15:0] r;
        int beats;

        prbs[0] = 15'h7FFF;
        for (int i = 1; i < 32767; i++) prbs[i] = prbs_step(prbs[i-1]);
        check("model_prbs_second", {17'd0, prbs[1]}, 32'h0000_7FFE);
        check("model_prbs_period", {17'd0, prbs_step(prbs[32766])}, 32'h0000_7FFF);

        #3 rstn = 1'b0;
        #1;
        check("rst_tvalid", {31'd0, tvalid}, 32'd0);
        check("rst_tdata", tdata, 32'd0);
        check("rst_tlast", {31'd0, tlast}, 32'd0);
        check("rst_active", {31'd0, act}, 32'd0);
        check("rst_pkt_count", {16'd0, pcnt}, 32'd0);
        tick(); tick();
        rstn = 1'b1;
        armed = 1'b1;

        // Ramp with a three-cycle start delay.
        md = 2'd0; ec = 16'd3; pl = 10'd3; rdy = 1'b1; en = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("ramp_delay_low", {31'd0, tvalid}, 32'd0);
        tick();
        check("ramp_valid_rise", {31'd0, tvalid}, 32'd1);
        check("ramp_w0", tdata, 32'h0000FFFF);
        tick(); check("ramp_w1", tdata, 32'h0001FFFE);
        tick(); check("ramp_w2", tdata, 32'h0002FFFD);
        tick(); check("ramp_w3", tdata, 32'h0003FFFC);
        check("ramp_tlast", {31'd0, tlast}, 32'd1);
        check("ramp_pkt0", {16'd0, pcnt}, 32'd0);
        tick();
        check("ramp_pkt1", {16'd0, pcnt}, 32'd1);
        check("ramp_w4", tdata, 32'h0004FFFB);
        en = 1'b0; dc = 16'd0;
        wait_idle(50);

        // Backpressure mid-packet.
        ec = 16'd0; pl = 10'd7; en = 1'b1;
        wait_valid(20);
        tick(); tick();
        rdy = 1'b0;
        save = tdata;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_data", tdata, save);
            check("bp_hold_valid", {31'd0, tvalid}, 32'd1);
        end
        rdy = 1'b1;
        tick();
        r = save[31:16] + 16'd1;
        check("bp_resume", tdata, {r, ~r});
        en = 1'b0; dc = 16'd1;
        wait_idle(50);

        // Stop with a disable delay: the session finishes its packet.
        pl = 10'd7; dc = 16'd2; en = 1'b1;
        wait_valid(20);
        beats = 0;
        for (int k = 0; k < 100 && tvalid; k++) begin
            if (beats == 2) en = 1'b0;
            beats++;
            tick();
        end
        check("stop_beats", beats, 32'd8);
        check("stop_pkt_count", {16'd0, pcnt}, 32'd1);
        check("stop_active", {31'd0, act}, 32'd0);

        // Abort during the start delay, then restart.
        ec = 16'd10; en = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        en = 1'b0;
        tick(); tick(); tick();
        check("abort_valid", {31'd0, tvalid}, 32'd0);
        check("abort_active", {31'd0, act}, 32'd0);
        ec = 16'd0; en = 1'b1;
        wait_valid(20);
        check("abort_restart_w0", tdata, 32'h0000FFFF);
        en = 1'b0; dc = 16'd0;
        wait_idle(50);

        // PRBS15 full period with single-beat packets.
        md = 2'd2; pl = 10'd0; ec = 16'd0; en = 1'b1;
        wait_valid(20);
        check("prbs_w0", tdata, 32'h7FFF0000);
        check("prbs_tlast", {31'd0, tlast}, 32'd1);
        tick();
        check("prbs_w1", tdata, 32'h7FFE0001);
        for (int i = 1; i < 32767; i++) tick();
        check("prbs_wrap", tdata, 32'h7FFF0000);
        check("prbs_pkts", {16'd0, pcnt}, 32'd32767);
        en = 1'b0;
        wait_idle(50);

        // Toggle pattern, then reset mid-packet.
        md = 2'd3; cd = 32'h12345678; pl = 10'd2; ec = 16'd1; en = 1'b1;
        wait_valid(20);
        check("toggle_w0", tdata, 32'h12345678);
        tick();
        check("toggle_w1", tdata, 32'hEDCBA987);
        tick(); tick(); tick();
        check("toggle_pkt1", {16'd0, pcnt}, 32'd1);
        check("toggle_w4", tdata, 32'h12345678);
        en = 1'b0;
        rstn = 1'b0;
        #1;
        check("mrst_tvalid", {31'd0, tvalid}, 32'd0);
        check("mrst_tdata", tdata, 32'd0);
        check("mrst_tlast", {31'd0, tlast}, 32'd0);
        check("mrst_active", {31'd0, act}, 32'd0);
        check("mrst_pkt_count", {16'd0, pcnt}, 32'd0);
        tick();
        rstn = 1'b1;

        // Random sessions; inputs change mid-session to exercise latching.
        for (int c = 0; c < 4000; c++) begin
            rdy = ($urandom_range(0, 9) < 7);
            md  = 2'($urandom_range(0, 3));
            cd  = $urandom;
            pl  = 10'($urandom_range(0, 5));
            ec  = 16'($urandom_range(0, 4));
            dc  = 16'($urandom_range(0, 5));
            if ($urandom_range(0, 11) == 0) en = ~en;
            if ($urandom_range(0, 999) == 0) begin
                rstn = 1'b0;
                tick();
                rstn = 1'b1;
            end
            tick();
        end
        en = 1'b0; rdy = 1'b1;
        wait_idle(200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adrv9001_axis_pattern_gen.md
Name: adrv9001_axis_pattern_gen

Overview:
- AXI4-Stream source that generates IQ test patterns for the ADRV9001 TX datapath; it is the driving end of the stream that the TX/RX capture monitor observes.
- Streaming is gated by an enable request, with a programmable start delay and a programmable stop delay. Packets are framed with tlast at a programmable length.
- Sits between the PL control logic and the ADRV9001 TX interface in the single TX clock domain.

Parameters:
- PKT_WIDTH, 10, width of pkt_len and of the in-packet beat counter.
- CNT_WIDTH, 16, width of enable_cnt, disable_cnt and pkt_count.

Ports:
- clk  input  1  stream clock; all logic is on the rising edge.
- rstn  input  1  asynchronous active-low reset.
- enable  input  1  level streaming request (already in the clk domain).
- mode  input  2  pattern select: 0 ramp, 1 constant, 2 PRBS15, 3 toggle.
- const_data  input  32  pattern word for modes 1 and 3; [31:16]=I, [15:0]=Q.
- pkt_len  input  PKT_WIDTH  packet length minus 1, in beats.
- enable_cnt  input  CNT_WIDTH  cycles from enable rise to tvalid.
- disable_cnt  input  CNT_WIDTH  cycles streaming continues after enable falls.
- m_axis_tdata  output  32  IQ sample, {I,Q}.
- m_axis_tvalid  output  1  AXIS valid.
- m_axis_tready  input  1  AXIS ready.
- m_axis_tlast  output  1  last beat of packet.
- active  output  1  high in any state other than IDLE.
- pkt_count  output  CNT_WIDTH  packets completed in the current session.

Behaviour:
- Reset (rstn=0, asynchronous): state=IDLE, tvalid=0, tlast=0, tdata=0, active=0, pkt_count=0, beat counter=0, ramp=0, LFSR=15'h7FFF.
- Handshake: a beat transfers when tvalid & tready. tdata and tlast hold stable while tvalid=1 and tready=0. tvalid never falls before a handshake.
- FSM states: IDLE, EN_DELAY, STREAM, DIS_DELAY, FLUSH.
- IDLE -> EN_DELAY when enable=1:
  - load delay counter with enable_cnt;
  - latch mode, const_data and pkt_len;
  - clear pkt_count, beat counter and ramp; reseed LFSR to 15'h7FFF.
- EN_DELAY:
  - enable=0 -> IDLE; no beat is emitted.
  - Otherwise, counter!=0 decrements; counter==0 -> STREAM.
  - tvalid rises enable_cnt+1 cycles after the edge at which enable is first sampled high.
- STREAM: tvalid=1. enable=0 -> DIS_DELAY and load the counter with disable_cnt.
- DIS_DELAY: streaming continues.
  - enable=1 -> STREAM.
  - Otherwise, counter!=0 decrements; counter==0 -> FLUSH.
- FLUSH: streaming continues until the handshake of a beat with tlast=1, then IDLE with tvalid=0 on the next cycle.
  - If the current beat is already a tlast beat, that handshake ends the session.
  - enable during FLUSH is ignored; a new session starts only from IDLE.
- Framing:
  - The beat counter increments on each handshake and wraps to 0 after the beat where counter==latched pkt_len.
  - tlast = (beat counter == latched pkt_len). pkt_len=0 gives tlast on every beat.
  - Sessions always end on a packet boundary.
- pkt_count increments on each tlast handshake and saturates at all-ones.
- Patterns (next word is computed on handshake; the first word is valid when tvalid rises):
  - Ramp: I=ramp, Q=~ramp; ramp starts at 0, +1 per beat, wraps mod 2^16.
  - Constant: const_data.
  - PRBS15: polynomial x^15+x^14+1, advanced one step per beat; I={1'b0,lfsr}, Q={1'b0,~lfsr}; first word uses the seed 15'h7FFF.
  - Toggle: const_data on even beats, ~const_data on odd beats (beat parity is counted from session start).
- Latched mode, const_data and pkt_len ignore input changes mid-session.
- Mid-operation reset: returns immediately to the reset values. No handshake completes on that edge.

Test Plan:
- Ramp, enable_cnt=3, pkt_len=3, tready=1, enable high: tvalid rises 4 cycles after enable is sampled. tdata sequence is 0000FFFF, 0001FFFE, 0002FFFD, 0003FFFC with tlast on beat 4; pkt_count=1 after beat 4.
- Backpressure: in ramp mode, drive tready low for 5 cycles mid-packet. tdata, tlast and tvalid stay frozen; the sequence resumes without gap or repeat.
- Stop: pkt_len=7, disable_cnt=2, enable drops at beat 2. Streaming continues through beat 8 (tlast); tvalid falls the cycle after. pkt_count=1 and active=0.
- Abort in delay: enable_cnt=10, enable drops after 4 cycles. No tvalid, return to IDLE; a re-enable restarts the ramp at 0.
- PRBS15, pkt_len=0: first word {0x7FFF,0x0000}; every beat has tlast; after 32767 beats the LFSR returns to 7FFF.
- Toggle with const_data=0x12345678; also assert rstn low mid-packet: words alternate 12345678, EDCBA987. On reset, all outputs go to 0 immediately and state is IDLE.
